// File: rtl/fabric_port_out_vc.sv
// VC-aware NoC-to-fabric output port: per-VC flit FIFOs with credit return,
// packet-granular round-robin arbitration and packing of up to RATIO flits per word.
module fabric_port_out_vc #(
    parameter int WIDTH_NOC        = 36,
    parameter int NUM_VC           = 2,
    parameter int DEPTH_PER_VC     = 8,
    parameter int RATIO            = 4,
    parameter int WIDTH_RTL        = RATIO * WIDTH_NOC,
    parameter int VC_ADDRESS_WIDTH = $clog2(NUM_VC),
    parameter int COUNT_WIDTH      = $clog2(RATIO + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WIDTH_NOC-1:0]        noc_flit_in,
    output logic [NUM_VC-1:0]           noc_credits_out,
    output logic [WIDTH_RTL-1:0]        rtl_packet_out,
    output logic                        rtl_valid_out,
    input  logic                        rtl_ready_in,
    output logic [VC_ADDRESS_WIDTH-1:0] rtl_vc_out,
    output logic [COUNT_WIDTH-1:0]      rtl_count_out,
    output logic                        rtl_last_out,
    output logic                        overflow_err
);
    localparam int VCW    = VC_ADDRESS_WIDTH;
    localparam int ADDR_W = $clog2(DEPTH_PER_VC);
    localparam int FILL_W = ADDR_W + 1;
    localparam logic [COUNT_WIDTH-1:0] LAST_SLOT = COUNT_WIDTH'(RATIO - 1);

    typedef enum logic {ASSEMBLE, HOLD} state_t;

    state_t state_reg, state_next;

    logic                 flit_valid;
    logic                 flit_tail;
    logic [VCW-1:0]       flit_vc;
    logic [NUM_VC-1:0]    fifo_empty;
    logic [NUM_VC-1:0]    fifo_full;
    logic [NUM_VC-1:0]    push;
    logic [NUM_VC-1:0]    pop;
    logic [NUM_VC-1:0]    ovf_hit;
    logic [WIDTH_NOC-1:0] head_flit [NUM_VC];

    logic                   locked_reg;
    logic [VCW-1:0]         locked_vc_reg;
    logic [VCW-1:0]         rr_ptr_reg;
    logic [COUNT_WIDTH-1:0] count_reg;
    logic                   last_reg;
    logic                   overflow_reg;
    logic [NUM_VC-1:0]      credits_reg;

    logic                 arb_found;
    logic [VCW-1:0]       arb_vc;
    logic [VCW-1:0]       sel_vc;
    logic [WIDTH_NOC-1:0] sel_flit;
    logic                 sel_tail;
    logic                 pop_en;
    logic                 word_done;
    logic                 word_accept;

    assign flit_valid = noc_flit_in[WIDTH_NOC-1];
    assign flit_tail  = noc_flit_in[WIDTH_NOC-3];
    assign flit_vc    = noc_flit_in[WIDTH_NOC-4 -: VCW];

    // Per-VC circular FIFO; a push into a full FIFO is still accepted when
    // the same VC is popped in that cycle.
    generate
        for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_fifo
            logic [WIDTH_NOC-1:0] mem [DEPTH_PER_VC];
            logic [ADDR_W-1:0]    wr_ptr_reg;
            logic [ADDR_W-1:0]    rd_ptr_reg;
            logic [FILL_W-1:0]    fill_reg;
            logic                 hit;

            assign hit            = flit_valid && (flit_vc == VCW'(gi));
            assign fifo_empty[gi] = (fill_reg == '0);
            assign fifo_full[gi]  = (fill_reg == FILL_W'(DEPTH_PER_VC));
            assign push[gi]       = hit && (!fifo_full[gi] || pop[gi]);
            assign ovf_hit[gi]    = hit && fifo_full[gi] && !pop[gi];
            assign head_flit[gi]  = mem[rd_ptr_reg];

            always_ff @(posedge clk) begin
                if (push[gi]) begin
                    mem[wr_ptr_reg] <= noc_flit_in;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    fill_reg   <= '0;
                end else begin
                    if (push[gi]) wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
                    if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
                    case ({push[gi], pop[gi]})
                        2'b10:   fill_reg <= fill_reg + FILL_W'(1);
                        2'b01:   fill_reg <= fill_reg - FILL_W'(1);
                        default: fill_reg <= fill_reg;
                    endcase
                end
            end
        end
    endgenerate

    // Descending scan so the smallest offset from rr_ptr wins.
    always_comb begin
        int           idx;
        logic [VCW-1:0] idx_v;
        arb_found = |(~fifo_empty);
        arb_vc    = '0;
        for (int i = NUM_VC - 1; i >= 0; i--) begin
            idx   = (int'(rr_ptr_reg) + i) % NUM_VC;
            idx_v = VCW'(idx);
            if (!fifo_empty[idx_v]) begin
                arb_vc = idx_v;
            end
        end
    end

    assign sel_vc      = locked_reg ? locked_vc_reg : arb_vc;
    assign sel_flit    = head_flit[sel_vc];
    assign sel_tail    = sel_flit[WIDTH_NOC-3];
    assign pop_en      = (state_reg == ASSEMBLE) &&
                         (locked_reg ? !fifo_empty[locked_vc_reg] : arb_found);
    assign word_done   = pop_en && (sel_tail || (count_reg == LAST_SLOT));
    assign word_accept = (state_reg == HOLD) && rtl_ready_in;

    generate
        for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_pop
            assign pop[gi] = pop_en && (sel_vc == VCW'(gi));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ASSEMBLE: if (word_done)    state_next = HOLD;
            HOLD:     if (rtl_ready_in) state_next = ASSEMBLE;
            default:                    state_next = ASSEMBLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ASSEMBLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // The lock is released only when the word carrying the tail leaves HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            locked_reg    <= 1'b0;
            locked_vc_reg <= '0;
            rr_ptr_reg    <= '0;
            count_reg     <= '0;
            last_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
            credits_reg   <= '0;
        end else begin
            credits_reg  <= pop;
            overflow_reg <= overflow_reg | (|ovf_hit);
            if (pop_en) begin
                locked_reg    <= 1'b1;
                locked_vc_reg <= sel_vc;
                count_reg     <= count_reg + COUNT_WIDTH'(1);
                if (sel_tail) last_reg <= 1'b1;
            end
            if (word_accept) begin
                count_reg <= '0;
                last_reg  <= 1'b0;
                if (last_reg) begin
                    locked_reg <= 1'b0;
                    rr_ptr_reg <= (locked_vc_reg == VCW'(NUM_VC - 1)) ?
                                  '0 : locked_vc_reg + VCW'(1);
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < RATIO; gi++) begin : g_slot
            logic [WIDTH_NOC-1:0] slot_reg;

            always_ff @(posedge clk) begin
                if (rst || word_accept) begin
                    slot_reg <= '0;
                end else if (pop_en && (count_reg == COUNT_WIDTH'(gi))) begin
                    slot_reg <= sel_flit;
                end
            end

            assign rtl_packet_out[gi*WIDTH_NOC +: WIDTH_NOC] = slot_reg;
        end
    endgenerate

    assign noc_credits_out = credits_reg;
    assign rtl_valid_out   = (state_reg == HOLD);
    assign rtl_vc_out      = locked_vc_reg;
    assign rtl_count_out   = count_reg;
    assign rtl_last_out    = last_reg;
    assign overflow_err    = overflow_reg;

endmodule
